bus_xfer_arbiter: RTL and testbench
===================================

// Module: bus_xfer_arbiter
// PURPOSE
//  Shares the 8-bit tri-state CPU bus between NUM_REQ requesters (control unit, debug port, ...).
//  Each request is a register-to-register move (src -> dst). The block round-robin arbitrates the requests.
//  It sequences the per-register rd_en/wr_en strobes so at most one register drives the bus at any time.
//  It sits between the requesters and the bank of bus registers.
// PARAMETERS
//  NUM_REQ  4  number of requesters (2..8)
//  NUM_REG  4  number of bus registers controlled (2..16)
//  IDX_W    $clog2(NUM_REG)  register index width; derived, do not override
// PORTS
//  clk       in   1                clock; all logic on posedge
//  clr_n     in   1                asynchronous active-low reset
//  req       in   NUM_REQ          per-requester transfer request; level, held until done
//  req_src   in   NUM_REQ*IDX_W    packed source index; slice i belongs to req[i]
//  req_dst   in   NUM_REQ*IDX_W    packed destination index; slice i belongs to req[i]
//  grant     out  NUM_REQ          one-hot; high for the owner from DRIVE through RELEASE
//  done      out  NUM_REQ          one-cycle pulse to the owner in RELEASE
//  err       out  1                one-cycle pulse with done when the request was rejected
//  rd_en     out  NUM_REG          one-hot-or-zero; register drives the bus
//  wr_en     out  NUM_REG          one-hot-or-zero; register captures the bus
//  busy      out  1                high in any state other than IDLE
//  xfer_cnt  out  16               count of completed transfers (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (clr_n=0, async): state=IDLE, rr_ptr=0, and all outputs are 0.
//  - All outputs are registered (decoded from state and latched indices); no combinational path from req.
//  - FSM: IDLE -> DRIVE -> WRITE -> RELEASE -> IDLE.
//    - IDLE: if any req bit is set, pick a winner by round robin starting at rr_ptr.
//      - Latch the winner's src/dst and set rr_ptr = winner+1 (mod NUM_REQ).
//      - Go to DRIVE. If no req, stay in IDLE.
//    - DRIVE: grant[w]=1 and rd_en[src]=1; the bus settles.
//    - WRITE: rd_en[src]=1 and wr_en[dst]=1; dst captures the bus on the edge that ends WRITE.
//    - RELEASE: rd_en=0, wr_en=0 (bus turnaround cycle), grant[w]=1, done[w]=1. Next state is IDLE.
//  - Latency: req sampled high at edge N -> DRIVE at N+1, WRITE at N+2, done at N+3.
//    The next grant is no earlier than N+4, so a transfer takes 4 cycles including the IDLE cycle.
//  - Reject: if src==dst, or src or dst >= NUM_REG, the request is rejected.
//    - The FSM goes IDLE -> RELEASE directly and pulses done[w] and err.
//    - No rd_en or wr_en is asserted, and xfer_cnt does not increment.
//  - A req that drops mid-transfer does not abort it: the transfer completes and done still pulses.
//  - The requester must deassert req in the cycle after done, or it is arbitrated again.
//  - Simultaneous requests: the first set bit at or after rr_ptr, wrapping, wins; the others wait.
//  - Invariant: at most one rd_en bit and at most one wr_en bit is set in any cycle.
//    rd_en and wr_en are never set for the same index.
//  - clr_n asserted mid-transfer: everything returns to IDLE immediately and no done is issued.
//    The destination register is unchanged unless its capture edge already occurred.
// CONFIGURATION
//  - Macro XFER_CNT_EN.
//  - Defined: xfer_cnt is a 16-bit counter.
//    - It increments on each non-rejected RELEASE and saturates at 16'hFFFF.
//    - It resets to 0.
//  - Undefined: no counter flops are generated and xfer_cnt is tied to 16'h0000.
// STRUCTURE
//  - Package bus_ctrl_pkg holds:
//    - the state enum (IDLE, DRIVE, WRITE, RELEASE) with a 2-bit encoding;
//    - the index-width helper function;
//    - the XFER_CNT_W=16 constant.
//  - Sub-module rr_arbiter (NUM_REQ): combinational pick of a one-hot winner from req and rr_ptr.
//    The top-level module owns the FSM, the latched indices, the strobe decode and the counter.
// TESTING
//  - Single request: req[0]=1, src=1, dst=2, bus reg1=8'hA5.
//    -> rd_en=4'b0010 for 2 cycles, wr_en=4'b0100 in WRITE only, done[0] at N+3, reg2=8'hA5.
//  - Contention: req=4'b1111 held.
//    -> grants in order 0,1,2,3,0 with 4 cycles per grant; no two done bits are ever set together.
//  - Reject: src=dst=3 -> done and err pulse at N+1, rd_en/wr_en stay 0, xfer_cnt unchanged.
//  - Out of range: with NUM_REG=3, dst=3 -> err pulse and no strobes.
//  - Reset mid-transfer: drop clr_n during WRITE.
//    -> all outputs are 0 in the same cycle; after release the FSM is in IDLE with rr_ptr=0.
//  - With XFER_CNT_EN defined: 5 good and 2 rejected transfers -> xfer_cnt=5.
//    Without the macro, xfer_cnt stays 0.
//    All runs check the one-hot strobe invariant with an assertion every cycle.

Source files
------------

// File: rtl/bus_xfer_arbiter_pkg.sv
// Shared types and helpers for the bus transfer arbiter: FSM state encoding,
// index-width helper and transfer-counter width.
package bus_ctrl_pkg;

  localparam int XFER_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    WRITE   = 2'd2,
    RELEASE = 2'd3
  } xfer_state_e;

  // Width of an index able to address n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_xfer_arbiter_if.sv
// Requester/register-bank side signals of the bus transfer arbiter.
// master: requesters and register bank; slave: the arbiter itself.
interface bus_xfer_arbiter_if import bus_ctrl_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int NUM_REG = 4,
  parameter int IDX_W   = idx_width(NUM_REG)
) ();

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*IDX_W-1:0] req_src;
  logic [NUM_REQ*IDX_W-1:0] req_dst;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic                     err;
  logic [NUM_REG-1:0]       rd_en;
  logic [NUM_REG-1:0]       wr_en;
  logic                     busy;
  logic [XFER_CNT_W-1:0]    xfer_cnt;

  modport master (
    output req, req_src, req_dst,
    input  grant, done, err, rd_en, wr_en, busy, xfer_cnt
  );

  modport slave (
    input  req, req_src, req_dst,
    output grant, done, err, rd_en, wr_en, busy, xfer_cnt
  );

endinterface

// File: rtl/bus_xfer_arbiter_rr.sv
// Combinational round-robin pick: first set req bit at or after rr_ptr, wrapping.
module rr_arbiter import bus_ctrl_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [PTR_W-1:0]   win_idx,
  output logic               any
);

  always_comb begin
    logic [PTR_W-1:0] pos;
    pos     = '0;
    win     = '0;
    win_idx = '0;
    any     = |req;
    // Walk from farthest to nearest so the nearest candidate is written last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = PTR_W'((32'(rr_ptr) + 32'(k)) % NUM_REQ);
      if (req[pos]) begin
        win      = '0;
        win[pos] = 1'b1;
        win_idx  = pos;
      end
    end
  end

endmodule

// File: rtl/bus_xfer_arbiter.sv
// Round-robin arbiter sequencing register-to-register moves on a shared bus.
// Optional transfer counter enabled by defining XFER_CNT_EN.
module bus_xfer_arbiter import bus_ctrl_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int NUM_REG = 4,
  parameter int IDX_W   = idx_width(NUM_REG)
) (
  input logic               clk,
  input logic               clr_n,
  bus_xfer_arbiter_if.slave bus
);

  localparam int PTR_W = idx_width(NUM_REQ);

  xfer_state_e          state_q, state_nxt;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_nxt;
  logic [NUM_REQ-1:0]   own_q, own_nxt;
  logic                 rej_q, rej_nxt;
  logic [IDX_W-1:0]     src_q, src_nxt, dst_q, dst_nxt;

  logic [NUM_REQ-1:0]   win;
  logic [PTR_W-1:0]     win_idx;
  logic                 win_any;
  logic [IDX_W-1:0]     win_src, win_dst;
  logic                 win_rej;

  logic [NUM_REQ-1:0]   grant_d, done_d, grant_q, done_q;
  logic [NUM_REG-1:0]   rd_d, wr_d, rd_q, wr_q;
  logic                 err_d, busy_d, err_q, busy_q;

  function automatic logic [NUM_REG-1:0] reg_dec(input logic [IDX_W-1:0] idx);
    reg_dec = '0;
    for (int i = 0; i < NUM_REG; i++) begin
      if (idx == IDX_W'(i)) reg_dec[i] = 1'b1;
    end
  endfunction

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req     (bus.req),
    .rr_ptr  (rr_ptr_q),
    .win     (win),
    .win_idx (win_idx),
    .any     (win_any)
  );

  always_comb begin
    win_src = '0;
    win_dst = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) begin
        win_src = bus.req_src[i*IDX_W +: IDX_W];
        win_dst = bus.req_dst[i*IDX_W +: IDX_W];
      end
    end
    win_rej = (win_src == win_dst) ||
              (32'(win_src) >= 32'(NUM_REG)) ||
              (32'(win_dst) >= 32'(NUM_REG));
  end

  // State register and control latches
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      own_q    <= '0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      rr_ptr_q <= rr_ptr_nxt;
      own_q    <= own_nxt;
      rej_q    <= rej_nxt;
    end
  end

  always_ff @(posedge clk) begin
    src_q <= src_nxt;
    dst_q <= dst_nxt;
  end

  // Next-state and latched-transfer logic
  always_comb begin
    state_nxt  = state_q;
    rr_ptr_nxt = rr_ptr_q;
    own_nxt    = own_q;
    rej_nxt    = rej_q;
    src_nxt    = src_q;
    dst_nxt    = dst_q;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_nxt  = win_rej ? RELEASE : DRIVE;
          rr_ptr_nxt = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          own_nxt    = win;
          rej_nxt    = win_rej;
          src_nxt    = win_src;
          dst_nxt    = win_dst;
        end
      end
      DRIVE:   state_nxt = WRITE;
      WRITE:   state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state so they can be registered
  always_comb begin
    grant_d = '0;
    done_d  = '0;
    err_d   = 1'b0;
    rd_d    = '0;
    wr_d    = '0;
    busy_d  = (state_nxt != IDLE);
    case (state_nxt)
      DRIVE: begin
        grant_d = own_nxt;
        rd_d    = reg_dec(src_nxt);
      end
      WRITE: begin
        grant_d = own_nxt;
        rd_d    = reg_dec(src_nxt);
        wr_d    = reg_dec(dst_nxt);
      end
      RELEASE: begin
        grant_d = own_nxt;
        done_d  = own_nxt;
        err_d   = rej_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.rd_en = rd_q;
  assign bus.wr_en = wr_q;
  assign bus.busy  = busy_q;

`ifdef XFER_CNT_EN
  logic [XFER_CNT_W-1:0] cnt_q;

  // Counts completed moves only; saturates instead of wrapping.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else if (state_q == RELEASE && !rej_q && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.xfer_cnt = cnt_q;
`else
  assign bus.xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_xfer_arbiter.sv
// Directed testbench for bus_xfer_arbiter: a 4x4 instance with a register-bank
// model and a 2-requester / 3-register instance for out-of-range indices.
module tb_bus_xfer_arbiter;
  import bus_ctrl_pkg::*;

`ifdef XFER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  bus_xfer_arbiter_if #(.NUM_REQ(4), .NUM_REG(4)) bus ();
  bus_xfer_arbiter_if #(.NUM_REQ(2), .NUM_REG(3)) bus3 ();

  bus_xfer_arbiter #(.NUM_REQ(4), .NUM_REG(4)) dut (
    .clk(clk), .clr_n(clr_n), .bus(bus)
  );
  bus_xfer_arbiter #(.NUM_REQ(2), .NUM_REG(3)) dut3 (
    .clk(clk), .clr_n(clr_n), .bus(bus3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // {grant, done, err, rd_en, wr_en, busy}
  logic [17:0] obs;
  logic [11:0] obs3;
  assign obs  = {bus.grant, bus.done, bus.err, bus.rd_en, bus.wr_en, bus.busy};
  assign obs3 = {bus3.grant, bus3.done, bus3.err, bus3.rd_en, bus3.wr_en, bus3.busy};

  // Register bank on the shared bus
  logic [7:0] bank [4];
  logic [7:0] bus_data;
  logic       bank_init = 1'b1;

  always_comb begin
    bus_data = 8'h00;
    for (int k = 0; k < 4; k++) if (bus.rd_en[k]) bus_data = bank[k];
  end

  always @(posedge clk) begin
    if (bank_init) begin
      bank[0] <= 8'h00;
      bank[1] <= 8'hA5;
      bank[2] <= 8'h00;
      bank[3] <= 8'h3C;
    end else begin
      for (int k = 0; k < 4; k++) if (bus.wr_en[k]) bank[k] <= bus_data;
    end
  end

  always @(negedge clk) begin
    n_checks++;
    assert ($onehot0(bus.rd_en) && $onehot0(bus.wr_en) && ((bus.rd_en & bus.wr_en) == 4'b0) &&
            $onehot0(bus.done) && $onehot0(bus3.rd_en) && $onehot0(bus3.wr_en) &&
            ((bus3.rd_en & bus3.wr_en) == 3'b0) && $onehot0(bus3.done))
    else begin
      n_fail++;
      $display("FAIL strobe_invariant: rd=%b wr=%b done=%b rd3=%b wr3=%b done3=%b, required one-hot-or-zero and disjoint",
               bus.rd_en, bus.wr_en, bus.done, bus3.rd_en, bus3.wr_en, bus3.done);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int s, input int d);
    bus.req_src[i*2 +: 2] = 2'(s);
    bus.req_dst[i*2 +: 2] = 2'(d);
  endtask

  task automatic set_req3(input int i, input int s, input int d);
    bus3.req_src[i*2 +: 2] = 2'(s);
    bus3.req_dst[i*2 +: 2] = 2'(d);
  endtask

  task automatic test_reset();
    bus.req = '0;  bus.req_src = '0;  bus.req_dst = '0;
    bus3.req = '0; bus3.req_src = '0; bus3.req_dst = '0;
    clr_n = 1'b0;
    bank_init = 1'b1;
    tick(3);
    n_checks++;
    if (obs !== 18'h0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", obs); end
    n_checks++;
    if (bus.xfer_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", bus.xfer_cnt); end
    n_checks++;
    if (obs3 !== 12'h0) begin n_fail++; $display("FAIL reset_outputs3: got %h want 0", obs3); end
    clr_n = 1'b1;
    bank_init = 1'b0;
    tick(1);
    n_checks++;
    if (obs !== 18'h0) begin n_fail++; $display("FAIL idle_after_reset: got %h want 0", obs); end
  endtask

  // All four requesters held: grants 0,1,2,3,0, four cycles each.
  task automatic test_contention();
    logic [17:0] exp;
    logic [3:0]  g, rd, wr;
    int pos, w;
    for (int i = 0; i < 4; i++) set_req(i, (i % 2 == 0) ? 3 : 0, (i % 2 == 0) ? 0 : 3);
    bus.req = 4'b1111;
    for (int c = 1; c <= 20; c++) begin
      tick(1);
      pos = (c - 1) % 4;
      w   = ((c - 1) / 4) % 4;
      g   = 4'(1 << w);
      rd  = (w % 2 == 0) ? 4'b1000 : 4'b0001;
      wr  = (w % 2 == 0) ? 4'b0001 : 4'b1000;
      case (pos)
        0:       exp = {g, 4'b0, 1'b0, rd, 4'b0, 1'b1};
        1:       exp = {g, 4'b0, 1'b0, rd, wr, 1'b1};
        2:       exp = {g, g, 1'b0, 4'b0, 4'b0, 1'b1};
        default: exp = 18'h0;
      endcase
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL contention_cycle%0d: got %h want %h", c, obs, exp);
      end
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_reject();
    set_req(1, 3, 3);
    bus.req = 4'b0010;
    tick(1);
    n_checks++;
    if (obs !== {4'b0010, 4'b0010, 1'b1, 4'b0, 4'b0, 1'b1}) begin
      n_fail++; $display("FAIL reject_same_idx: got %h want %h", obs, {4'b0010, 4'b0010, 1'b1, 4'b0, 4'b0, 1'b1});
    end
    bus.req = 4'b0000;
    tick(1);
    n_checks++;
    if (obs !== 18'h0) begin n_fail++; $display("FAIL reject_idle: got %h want 0", obs); end
    set_req(2, 0, 0);
    bus.req = 4'b0100;
    tick(1);
    n_checks++;
    if (obs !== {4'b0100, 4'b0100, 1'b1, 4'b0, 4'b0, 1'b1}) begin
      n_fail++; $display("FAIL reject_second: got %h want %h", obs, {4'b0100, 4'b0100, 1'b1, 4'b0, 4'b0, 1'b1});
    end
    bus.req = 4'b0000;
    tick(1);
    n_checks++;
    if (bus.xfer_cnt !== (CNT_EN ? 16'd5 : 16'd0)) begin
      n_fail++; $display("FAIL cnt_after_rejects: got %0d want %0d", bus.xfer_cnt, CNT_EN ? 5 : 0);
    end
  endtask

  task automatic test_single();
    logic [17:0] tbl [4];
    tbl[0] = {4'b0001, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b1};
    tbl[1] = {4'b0001, 4'b0000, 1'b0, 4'b0010, 4'b0100, 1'b1};
    tbl[2] = {4'b0001, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b1};
    tbl[3] = 18'h0;
    set_req(0, 1, 2);
    bus.req = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      n_checks++;
      if (obs !== tbl[i]) begin n_fail++; $display("FAIL single_step%0d: got %h want %h", i, obs, tbl[i]); end
      if (i == 2) bus.req = 4'b0000;
    end
    n_checks++;
    if (bank[2] !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", bank[2]); end
    n_checks++;
    if (bus.xfer_cnt !== (CNT_EN ? 16'd6 : 16'd0)) begin
      n_fail++; $display("FAIL single_cnt: got %0d want %0d", bus.xfer_cnt, CNT_EN ? 6 : 0);
    end
  endtask

  task automatic test_out_of_range();
    logic [11:0] tbl [4];
    set_req3(0, 0, 3);
    bus3.req = 2'b01;
    tick(1);
    n_checks++;
    if (obs3 !== {2'b01, 2'b01, 1'b1, 3'b0, 3'b0, 1'b1}) begin
      n_fail++; $display("FAIL oor_dst: got %h want %h", obs3, {2'b01, 2'b01, 1'b1, 3'b0, 3'b0, 1'b1});
    end
    bus3.req = 2'b00;
    tick(1);
    tbl[0] = {2'b10, 2'b00, 1'b0, 3'b100, 3'b000, 1'b1};
    tbl[1] = {2'b10, 2'b00, 1'b0, 3'b100, 3'b001, 1'b1};
    tbl[2] = {2'b10, 2'b10, 1'b0, 3'b000, 3'b000, 1'b1};
    tbl[3] = 12'h0;
    set_req3(1, 2, 0);
    bus3.req = 2'b10;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      n_checks++;
      if (obs3 !== tbl[i]) begin n_fail++; $display("FAIL oor_good_step%0d: got %h want %h", i, obs3, tbl[i]); end
      if (i == 2) bus3.req = 2'b00;
    end
    set_req3(0, 3, 1);
    bus3.req = 2'b01;
    tick(1);
    n_checks++;
    if (obs3 !== {2'b01, 2'b01, 1'b1, 3'b0, 3'b0, 1'b1}) begin
      n_fail++; $display("FAIL oor_src: got %h want %h", obs3, {2'b01, 2'b01, 1'b1, 3'b0, 3'b0, 1'b1});
    end
    bus3.req = 2'b00;
    tick(1);
  endtask

  task automatic test_reset_mid();
    logic [17:0] tbl [3];
    set_req(2, 0, 2);
    bus.req = 4'b0100;
    tick(2);
    n_checks++;
    if (obs !== {4'b0100, 4'b0, 1'b0, 4'b0001, 4'b0100, 1'b1}) begin
      n_fail++; $display("FAIL mid_write: got %h want %h", obs, {4'b0100, 4'b0, 1'b0, 4'b0001, 4'b0100, 1'b1});
    end
    clr_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 18'h0) begin n_fail++; $display("FAIL mid_reset_outputs: got %h want 0", obs); end
    n_checks++;
    if (bus.xfer_cnt !== 16'h0) begin n_fail++; $display("FAIL mid_reset_cnt: got %0d want 0", bus.xfer_cnt); end
    bus.req = 4'b0000;
    tick(1);
    n_checks++;
    if (bank[2] !== 8'hA5) begin n_fail++; $display("FAIL mid_dst_kept: got %h want a5", bank[2]); end
    clr_n = 1'b1;
    // rr_ptr back at 0: requester 0 must beat requester 3.
    set_req(0, 1, 2);
    set_req(3, 3, 0);
    bus.req = 4'b1001;
    tbl[0] = {4'b0001, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b1};
    tbl[1] = {4'b0001, 4'b0000, 1'b0, 4'b0010, 4'b0100, 1'b1};
    tbl[2] = {4'b0001, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b1};
    for (int i = 0; i < 3; i++) begin
      tick(1);
      n_checks++;
      if (obs !== tbl[i]) begin n_fail++; $display("FAIL post_reset_step%0d: got %h want %h", i, obs, tbl[i]); end
      if (i == 0) bus.req = 4'b0000;
    end
    tick(1);
    n_checks++;
    if (obs !== 18'h0) begin n_fail++; $display("FAIL post_reset_idle: got %h want 0", obs); end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_reject();
    test_single();
    test_out_of_range();
    test_reset_mid();
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
